// File: rtl/front_panel_button.sv
// Front-panel pushbutton receiver: synchronise, debounce and classify presses as short or long.
// Optional LED acknowledge stretcher is enabled by defining LED_ACK_EN.
module front_panel_button #(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned LONG_TICKS     = 2000,
  parameter int unsigned ACK_TICKS      = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic press_ack_n
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);

  logic [1:0]        sync_q;
  logic              pressed_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  state_t            state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              from_long, from_long_nxt;
  logic              level_nxt, short_nxt, long_nxt;

  // Sync flops reset to the released level so reset never looks like a press.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], button_n};
  end

  assign pressed_s = ~sync_q[1];

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      from_long   <= 1'b0;
      btn_level   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_nxt;
      from_long   <= from_long_nxt;
      btn_level   <= level_nxt;
      short_press <= short_nxt;
      long_press  <= long_nxt;
    end
  end

  // NOTE: every signal gets a default before the case, so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    deb_nxt       = deb_cnt;
    hold_nxt      = hold_cnt;
    from_long_nxt = from_long;
    level_nxt     = btn_level;
    short_nxt     = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (pressed_s) begin
          state_nxt = DEB_PRESS;
          deb_nxt   = '0;
        end
      end

      DEB_PRESS: begin
        if (!pressed_s) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_TICKS)) begin
          state_nxt     = PRESSED;
          level_nxt     = 1'b1;
          hold_nxt      = '0;
          from_long_nxt = 1'b0;
        end else if (tick) begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end

      // Threshold is checked before release so a simultaneous release still yields long_press.
      PRESSED: begin
        if (hold_cnt == HOLD_W'(LONG_TICKS)) begin
          state_nxt     = LONG_HELD;
          long_nxt      = 1'b1;
          from_long_nxt = 1'b1;
        end else if (!pressed_s) begin
          state_nxt = DEB_RELEASE;
          deb_nxt   = '0;
        end else if (tick) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      LONG_HELD: begin
        if (!pressed_s) begin
          state_nxt = DEB_RELEASE;
          deb_nxt   = '0;
        end
      end

      DEB_RELEASE: begin
        if (pressed_s) begin
          state_nxt = from_long ? LONG_HELD : PRESSED;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_TICKS)) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
          short_nxt = ~from_long;
        end else if (tick) begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifdef LED_ACK_EN
  localparam int ACK_W = $clog2(ACK_TICKS + 1);

  logic [ACK_W-1:0] ack_cnt;

  // Loading on the next-state pulse lines the ack up with the cycle the event is visible.
  always_ff @(posedge clk) begin
    if (rst)                         ack_cnt <= '0;
    else if (short_nxt || long_nxt)  ack_cnt <= ACK_W'(ACK_TICKS);
    else if (tick && ack_cnt != '0)  ack_cnt <= ack_cnt - 1'b1;
  end

  assign press_ack_n = (ack_cnt == '0);
`else
  // Ack path absent: output idles high; ACK_TICKS kept referenced so both builds share one interface.
  assign press_ack_n = 1'b1 | ACK_TICKS[0];
`endif

endmodule

// File: tb/tb_front_panel_button.sv
// Directed self-checking bench for front_panel_button (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=20, ACK_TICKS=5).
// Build with +define+LED_ACK_EN to exercise the acknowledge stretcher.
module tb_front_panel_button;

  logic clk;
  logic rst;
  logic button_n;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic press_ack_n;

  int n_checks = 0;
  int n_err    = 0;

  int short_cnt = 0;
  int long_cnt  = 0;
  int both_cnt  = 0;
  int rise_cnt  = 0;
  int ack_low   = 0;
  logic level_q = 1'b0;

  front_panel_button #(
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .LONG_TICKS    (20),
    .ACK_TICKS     (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_n   (button_n),
    .btn_level  (btn_level),
    .short_press(short_press),
    .long_press (long_press),
    .press_ack_n(press_ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor on the inactive edge.
  always @(negedge clk) begin
    if (short_press) short_cnt++;
    if (long_press)  long_cnt++;
    if (short_press && long_press) both_cnt++;
    if (!press_ack_n) ack_low++;
    if (btn_level && !level_q) rise_cnt++;
    level_q = btn_level;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic target, input int max, output int k);
    k = 0;
    while (btn_level !== target && k <= max) begin
      step();
      k++;
    end
  endtask

  task automatic wait_short(input int max, output int k);
    k = 0;
    while (short_press !== 1'b1 && k < max) begin
      step();
      k++;
    end
  endtask

  initial begin
    int k, j, a, s0, l0, r0, drops, elapsed;

    rst      = 1'b1;
    button_n = 1'b1;
    repeat (3) step();
    check("reset_btn_level",   btn_level,   1'b0);
    check("reset_short_press", short_press, 1'b0);
    check("reset_long_press",  long_press,  1'b0);
    check("reset_press_ack_n", press_ack_n, 1'b1);
    rst = 1'b0;
    repeat (5) step();

    // 1: two-clock glitch is rejected
    s0 = short_cnt; l0 = long_cnt; r0 = rise_cnt;
    button_n = 1'b0;
    repeat (2) step();
    button_n = 1'b1;
    repeat (30) step();
    check("t1_no_level_rise", rise_cnt - r0,  0);
    check("t1_no_short",      short_cnt - s0, 0);
    check("t1_no_long",       long_cnt - l0,  0);

    // 2: 40-clock press gives one short_press
    s0 = short_cnt; l0 = long_cnt;
    button_n = 1'b0;
    wait_level(1'b1, 40, k);
    check_range("t2_press_latency", k, 12, 16);
    if (k < 40) repeat (40 - k) step();
    button_n = 1'b1;
    wait_short(40, j);
    check("t2_short_seen",     short_press, 1'b1);
    check("t2_level_at_short", btn_level,   1'b0);
`ifdef LED_ACK_EN
    check("t6_ack_low_at_short", press_ack_n, 1'b0);
`endif
    step();
    check("t2_short_one_clk", short_press, 1'b0);
`ifdef LED_ACK_EN
    a = 1;
    while (press_ack_n !== 1'b1 && a < 40) begin
      step();
      a++;
    end
    check_range("t6_ack_width", a, 17, 20);
`endif
    repeat (10) step();
    check("t2_short_count", short_cnt - s0, 1);
    check("t2_long_count",  long_cnt - l0,  0);

    // 3: 150-clock hold gives one long_press and no short_press
    s0 = short_cnt; l0 = long_cnt;
    button_n = 1'b0;
    wait_level(1'b1, 40, k);
    check_range("t3_press_latency", k, 12, 16);
    j = 0;
    while (long_press !== 1'b1 && j < 120) begin
      step();
      j++;
    end
    check_range("t3_long_delay", j, 78, 82);
    check("t3_level_during_long", btn_level, 1'b1);
    step();
    check("t3_long_one_clk", long_press, 1'b0);
    elapsed = k + j + 1;
    if (elapsed < 150) repeat (150 - elapsed) step();
    button_n = 1'b1;
    wait_level(1'b0, 40, k);
    check_range("t3_release_latency", k, 12, 16);
    repeat (10) step();
    check("t3_short_count", short_cnt - s0, 0);
    check("t3_long_count",  long_cnt - l0,  1);

    // 4: 1-clock bounces while held do not drop the level or fire events
    s0 = short_cnt; l0 = long_cnt;
    button_n = 1'b0;
    wait_level(1'b1, 40, k);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (5) begin
        step();
        if (btn_level !== 1'b1) drops++;
      end
      button_n = 1'b1;
      step();
      if (btn_level !== 1'b1) drops++;
      button_n = 1'b0;
    end
    repeat (6) begin
      step();
      if (btn_level !== 1'b1) drops++;
    end
    check("t4_level_drops",         drops,          0);
    check("t4_no_events_in_bounce", (short_cnt - s0) + (long_cnt - l0), 0);
    button_n = 1'b1;
    wait_level(1'b0, 40, k);
    repeat (10) step();
    check("t4_short_count", short_cnt - s0, 1);
    check("t4_long_count",  long_cnt - l0,  0);

    // 5: reset while PRESSED clears outputs; held button re-debounces
    s0 = short_cnt; l0 = long_cnt;
    button_n = 1'b0;
    wait_level(1'b1, 40, k);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("t5_rst_btn_level",   btn_level,   1'b0);
    check("t5_rst_short_press", short_press, 1'b0);
    check("t5_rst_long_press",  long_press,  1'b0);
    check("t5_rst_press_ack_n", press_ack_n, 1'b1);
    rst = 1'b0;
    wait_level(1'b1, 40, k);
    check_range("t5_redebounce_latency", k, 12, 16);
    check("t5_no_events_on_rst", (short_cnt - s0) + (long_cnt - l0), 0);
    repeat (5) step();
    button_n = 1'b1;
    wait_level(1'b0, 40, k);
    repeat (10) step();
    check("t5_short_after_rst", short_cnt - s0, 1);
    check("t5_long_after_rst",  long_cnt - l0,  0);

    check("never_short_and_long", both_cnt, 0);
`ifndef LED_ACK_EN
    check("t6_ack_never_low", ack_low, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
